axis_frame_checker: RTL and testbench

- Synthesizable AXI4-Stream sink that sits directly downstream of system_top's s_axis_tx output (DMA video stream) in the validation environment.
- Applies a configurable pseudo-random tready backpressure pattern, checks frame/line framing against expected geometry, accumulates a per-frame checksum, and exposes counters and sticky error flags for the test classes to read.
- Replaces ad-hoc stream draining in the bench with a cycle-accurate, reusable checker.

---
 rtl/axis_frame_checker.sv | 169 ++++++++++++++++
 tb/tb_axis_frame_checker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_checker.sv
// AXI4-Stream video sink: LFSR-driven backpressure, frame/line geometry checks,
// per-frame lane-XOR checksum, frame counter and sticky error flags.
module axis_frame_checker #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_USER_WIDTH = 4,
    parameter int BEAT_CNT_WIDTH  = 16,
    parameter int LINE_CNT_WIDTH  = 16,
    parameter int FRAME_CNT_WIDTH = 32
) (
    input  logic                       aclk,
    input  logic                       aclk_reset,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tlast,
    input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,
    input  logic                       cfg_enable,
    input  logic                       cfg_bp_enable,
    input  logic [BEAT_CNT_WIDTH-1:0]  cfg_line_beats,
    input  logic [LINE_CNT_WIDTH-1:0]  cfg_frame_lines,
    input  logic                       err_clr,
    output logic                       frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic [31:0]                frame_checksum,
    output logic                       err_sof,
    output logic                       err_line_len,
    output logic                       err_frame_len
);
    localparam int LANES = AXIS_DATA_WIDTH / 32;

    typedef enum logic [1:0] {IDLE, LINE, WAIT_SOL} state_t;

    state_t                    state_q, state_d;
    logic [15:0]               lfsr_q;
    logic [BEAT_CNT_WIDTH-1:0] beat_q, beat_d, beats_now;
    logic [LINE_CNT_WIDTH-1:0] line_q, line_d, lines_now;
    logic [31:0]               csum_q, csum_d, csum_now, lane_xor;
    logic                      bad_q, bad_d, bad_now;
    logic                      take, line_ok, accept;
    logic                      set_sof, set_line, set_frame, done_d;
    logic                      sof, eof, sol;
    logic                      tuser_unused;

    assign sof          = s_axis_tuser[0];
    assign eof          = s_axis_tuser[1];
    assign sol          = s_axis_tuser[2];
    assign tuser_unused = ^s_axis_tuser;

    assign s_axis_tready = ~cfg_bp_enable | ~cfg_enable | lfsr_q[0] | lfsr_q[1];
    assign accept        = s_axis_tvalid & s_axis_tready;

    always_comb begin
        lane_xor = '0;
        for (int i = 0; i < LANES; i++) lane_xor ^= s_axis_tdata[i*32 +: 32];
    end

    // bad_q remembers a short/long line earlier in the frame so EOF cannot complete it
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        line_d    = line_q;
        csum_d    = csum_q;
        bad_d     = bad_q;
        beats_now = beat_q;
        lines_now = line_q;
        csum_now  = csum_q;
        bad_now   = bad_q;
        take      = 1'b0;
        line_ok   = 1'b0;
        set_sof   = 1'b0;
        set_line  = 1'b0;
        set_frame = 1'b0;
        done_d    = 1'b0;
        if (!cfg_enable) begin
            state_d = IDLE;
            beat_d  = '0;
            line_d  = '0;
            csum_d  = '0;
            bad_d   = 1'b0;
        end else if (accept) begin
            if (sof) begin
                set_sof   = (state_q != IDLE);
                take      = 1'b1;
                beats_now = BEAT_CNT_WIDTH'(1);
                lines_now = '0;
                csum_now  = lane_xor;
                bad_now   = 1'b0;
            end else begin
                case (state_q)
                    IDLE: set_sof = 1'b1;
                    LINE: begin
                        take      = 1'b1;
                        beats_now = (&beat_q) ? beat_q : beat_q + 1'b1;
                        csum_now  = csum_q + lane_xor;
                    end
                    WAIT_SOL: begin
                        if (sol) begin
                            take      = 1'b1;
                            beats_now = BEAT_CNT_WIDTH'(1);
                            csum_now  = csum_q + lane_xor;
                        end else begin
                            set_sof = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
            if (take) begin
                beat_d  = beats_now;
                line_d  = lines_now;
                csum_d  = csum_now;
                bad_d   = bad_now;
                state_d = LINE;
                if (s_axis_tlast) begin
                    line_ok  = (beats_now == cfg_line_beats);
                    set_line = ~line_ok;
                    bad_d    = bad_now | ~line_ok;
                    line_d   = lines_now + 1'b1;
                    beat_d   = '0;
                    if (eof) begin
                        if (line_d == cfg_frame_lines && !bad_d) done_d = 1'b1;
                        else                                     set_frame = 1'b1;
                        state_d = IDLE;
                    end else if (line_d == cfg_frame_lines) begin
                        set_frame = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = WAIT_SOL;
                    end
                end else if (eof) begin
                    set_frame = 1'b1;
                    state_d   = IDLE;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (aclk_reset) begin
            state_q        <= IDLE;
            lfsr_q         <= 16'hACE1;
            beat_q         <= '0;
            line_q         <= '0;
            csum_q         <= '0;
            bad_q          <= 1'b0;
            frame_done     <= 1'b0;
            frame_count    <= '0;
            frame_checksum <= '0;
            err_sof        <= 1'b0;
            err_line_len   <= 1'b0;
            err_frame_len  <= 1'b0;
        end else begin
            lfsr_q     <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            state_q    <= state_d;
            beat_q     <= beat_d;
            line_q     <= line_d;
            csum_q     <= csum_d;
            bad_q      <= bad_d;
            frame_done <= done_d;
            if (done_d) begin
                frame_count    <= frame_count + 1'b1;
                frame_checksum <= csum_d;
            end
            err_sof       <= (err_sof       & ~err_clr) | set_sof;
            err_line_len  <= (err_line_len  & ~err_clr) | set_line;
            err_frame_len <= (err_frame_len & ~err_clr) | set_frame;
        end
    end
endmodule

// File: tb/tb_axis_frame_checker.sv
// Directed bench for axis_frame_checker: framing, backpressure, error and reset cases.
module tb_axis_frame_checker;
    logic        tb_CLK = 1'b0;
    logic        aclk_reset;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic [3:0]  s_axis_tuser;
    logic        cfg_enable;
    logic        cfg_bp_enable;
    logic [15:0] cfg_line_beats;
    logic [15:0] cfg_frame_lines;
    logic        err_clr;
    logic        frame_done;
    logic [31:0] frame_count;
    logic [31:0] frame_checksum;
    logic        err_sof;
    logic        err_line_len;
    logic        err_frame_len;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int low_cnt;
    int d0;

    axis_frame_checker dut (
        .aclk(tb_CLK), .aclk_reset(aclk_reset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .cfg_enable(cfg_enable), .cfg_bp_enable(cfg_bp_enable),
        .cfg_line_beats(cfg_line_beats), .cfg_frame_lines(cfg_frame_lines),
        .err_clr(err_clr), .frame_done(frame_done), .frame_count(frame_count),
        .frame_checksum(frame_checksum), .err_sof(err_sof),
        .err_line_len(err_line_len), .err_frame_len(err_frame_len)
    );

    always #5 tb_CLK = ~tb_CLK;

    always @(posedge tb_CLK) if (frame_done) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at negedge; returns at the negedge after the beat is accepted.
    task automatic beat(input int d, input logic [3:0] u, input logic l);
        int n;
        logic r;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {32'h0, 32'(d)};
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        n = 0;
        do begin
            #1 r = s_axis_tready;
            @(posedge tb_CLK);
            @(negedge tb_CLK);
            n++;
        end while (!r && n < 200);
        if (!r) begin
            checks++;
            errors++;
            $error("FAIL beat_timeout: observed tready=0 expected acceptance within 200 cycles");
        end
    endtask

    task automatic frame(input int base, input int lines, input int beats,
                         input int eof_line, input int long_line);
        int k;
        int nb;
        logic [3:0] u;
        k = 0;
        for (int ln = 0; ln < lines; ln++) begin
            nb = (ln == long_line) ? beats + 1 : beats;
            for (int b = 0; b < nb; b++) begin
                u = 4'b0000;
                if (ln == 0 && b == 0) u[0] = 1'b1;
                if (b == 0) u[2] = 1'b1;
                if (b == nb - 1 && ln == eof_line) u[1] = 1'b1;
                beat(base + k, u, b == nb - 1);
                k++;
            end
            if (ln == eof_line) break;
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        aclk_reset = 1'b1;
        s_axis_tvalid = 1'b0;
        @(negedge tb_CLK);
        @(negedge tb_CLK);
        aclk_reset = 1'b0;
    endtask

    initial begin
        s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tlast = 0; s_axis_tuser = 0;
        cfg_enable = 1; cfg_bp_enable = 0; cfg_line_beats = 4; cfg_frame_lines = 3;
        err_clr = 0; aclk_reset = 1;
        @(negedge tb_CLK);
        do_reset();

        chk("rst_tready", s_axis_tready, 1);
        chk("rst_done", frame_done, 0);
        chk("rst_count", frame_count, 0);
        chk("rst_csum", frame_checksum, 0);
        chk("rst_errs", {err_sof, err_line_len, err_frame_len}, 3'b000);

        // good frame, no backpressure
        d0 = done_cnt;
        frame(0, 3, 4, 2, -1);
        chk("t1_done_pulse", frame_done, 1);
        chk("t1_count", frame_count, 1);
        chk("t1_csum", frame_checksum, 32'h42);
        chk("t1_errs", {err_sof, err_line_len, err_frame_len}, 3'b000);
        @(negedge tb_CLK);
        chk("t1_done_one_cycle", frame_done, 0);
        chk("t1_done_cnt", done_cnt - d0, 1);

        // good frame with backpressure
        do_reset();
        cfg_bp_enable = 1;
        frame(0, 3, 4, 2, -1);
        chk("t2_count", frame_count, 1);
        chk("t2_csum", frame_checksum, 32'h42);
        chk("t2_errs", {err_sof, err_line_len, err_frame_len}, 3'b000);
        low_cnt = 0;
        repeat (400) begin
            @(negedge tb_CLK);
            if (!s_axis_tready) low_cnt++;
        end
        chk("t2_bp_ratio", (low_cnt >= 60 && low_cnt <= 140), 1);
        cfg_bp_enable = 0;

        // long second line
        do_reset();
        d0 = done_cnt;
        frame(0, 3, 4, 2, 1);
        chk("t3_line_err", err_line_len, 1);
        chk("t3_frame_err", err_frame_len, 1);
        chk("t3_no_done", frame_done, 0);
        chk("t3_count", frame_count, 0);
        err_clr = 1;
        @(negedge tb_CLK);
        err_clr = 0;
        chk("t3_clr", {err_line_len, err_frame_len}, 2'b00);
        chk("t3_done_cnt", done_cnt - d0, 0);
        frame(0, 3, 4, 2, -1);
        chk("t3_recover_count", frame_count, 1);

        // SOF re-asserted on beat 6, then a clean frame
        do_reset();
        for (int i = 0; i < 6; i++)
            beat(i, (i == 0) ? 4'b0101 : (i == 4) ? 4'b0100 : (i == 5) ? 4'b0001 : 4'b0000, i == 3);
        frame(100, 3, 4, 2, -1);
        chk("t4_err_sof", err_sof, 1);
        chk("t4_done", frame_done, 1);
        chk("t4_count", frame_count, 1);
        chk("t4_csum", frame_checksum, 32'd1266);

        // EOF on line 2 of 3
        do_reset();
        frame(0, 3, 4, 1, -1);
        chk("t5_frame_err", err_frame_len, 1);
        chk("t5_line_ok", err_line_len, 0);
        chk("t5_no_done", frame_done, 0);
        chk("t5_count", frame_count, 0);

        // enable dropped mid-frame
        do_reset();
        for (int i = 0; i < 5; i++)
            beat(i, (i == 0) ? 4'b0101 : (i == 4) ? 4'b0100 : 4'b0000, i == 3);
        cfg_enable = 0;
        cfg_bp_enable = 1;
        s_axis_tvalid = 1; s_axis_tuser = 0; s_axis_tlast = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t6_tready_disabled", s_axis_tready, 1);
            @(negedge tb_CLK);
        end
        cfg_enable = 1; cfg_bp_enable = 0; s_axis_tvalid = 0;
        @(negedge tb_CLK);
        frame(0, 3, 4, 2, -1);
        chk("t6_count", frame_count, 1);
        chk("t6_errs", {err_sof, err_line_len, err_frame_len}, 3'b000);

        // stray beat sets err_sof, then reset mid-frame
        beat(7, 4'b0000, 1'b0);
        s_axis_tvalid = 0;
        @(negedge tb_CLK);
        chk("t7_stray_sof", err_sof, 1);
        for (int i = 0; i < 3; i++) beat(i, (i == 0) ? 4'b0101 : 4'b0000, 1'b0);
        aclk_reset = 1; s_axis_tvalid = 0;
        @(negedge tb_CLK);
        aclk_reset = 0;
        chk("t7_rst_tready", s_axis_tready, 1);
        chk("t7_rst_done", frame_done, 0);
        chk("t7_rst_count", frame_count, 0);
        chk("t7_rst_csum", frame_checksum, 0);
        chk("t7_rst_errs", {err_sof, err_line_len, err_frame_len}, 3'b000);
        frame(0, 3, 4, 2, -1);
        chk("t7_post_count", frame_count, 1);
        chk("t7_post_csum", frame_checksum, 32'h42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
